// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one spi_sram_encoder between two masters: port 0 (Hack CPU data
// port) and port 1 (screen fetcher / loader). A winner is picked in IDLE, its
// address / write-enable / write data are latched onto the encoder bus, the
// encoder request/busy handshake is run, and the winner gets a one-cycle ack
// together with registered read data.
//
// A watchdog bounds how long ISSUE waits for the encoder to raise busy. If it
// expires, the transaction completes with read data 0 and the sticky
// timeout_err flag is raised until reset.
//
// Optional build macro:
//   SRAM_ARB_ROUND_ROBIN_EN  - defined:   ties go to the port that did not
//                                         win the previous grant.
//                              undefined: fixed priority, port 0 wins ties.
module sram_port_arbiter #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     p0_req,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic                     p0_we,
  input  logic [WORD_WIDTH-1:0]    p0_wdata,
  output logic                     p0_ack,
  output logic [WORD_WIDTH-1:0]    p0_rdata,

  input  logic                     p1_req,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic                     p1_we,
  input  logic [WORD_WIDTH-1:0]    p1_wdata,
  output logic                     p1_ack,
  output logic [WORD_WIDTH-1:0]    p1_rdata,

  output logic                     mem_request,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_write_enable,
  output logic [WORD_WIDTH-1:0]    mem_wdata,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_busy,
  input  logic                     mem_initialized,

  output logic                     grant,
  output logic                     active,
  output logic                     timeout_err
);

  localparam int NUM_PORTS = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Per-port views so the datapath can be indexed by port number
  // ---------------------------------------------------------------------
  logic [NUM_PORTS-1:0]     port_req;
  logic [NUM_PORTS-1:0]     port_we;
  logic [ADDRESS_WIDTH-1:0] port_addr  [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    port_wdata [NUM_PORTS];

  assign port_req      = {p1_req, p0_req};
  assign port_we       = {p1_we, p0_we};
  assign port_addr[0]  = p0_addr;
  assign port_addr[1]  = p1_addr;
  assign port_wdata[0] = p0_wdata;
  assign port_wdata[1] = p1_wdata;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  logic [1:0]               state_reg,   state_next;
  logic                     grant_reg,   grant_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg,    addr_next;
  logic                     we_reg,      we_next;
  logic [WORD_WIDTH-1:0]    wdata_reg,   wdata_next;
  logic [TIMEOUT_WIDTH-1:0] wd_reg,      wd_next;
  logic                     timeout_reg, timeout_next;
  logic [WORD_WIDTH-1:0]    rdata_reg [NUM_PORTS];

  // Read-data register load controls, shared by the normal and timeout paths
  logic [NUM_PORTS-1:0]     rd_load;
  logic [WORD_WIDTH-1:0]    rd_value;

  logic                     can_grant;
  logic                     grant_fire;
  logic                     win_port;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;

  // A grant needs a ready encoder (initialised and idle) and a requester
  assign can_grant  = mem_initialized & ~mem_busy & (|port_req);
  assign grant_fire = (state_reg == IDLE) & can_grant;
  assign wd_inc     = wd_reg + WD_ONE;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Last winner; starts at port 1 so the very first tie goes to port 0
  logic last_grant_reg;

  // Remember each winner so the next tie favours the other port
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (grant_fire) begin
      last_grant_reg <= win_port;
    end
  end

  // Tie: the port that lost last time; lone requester: that requester
  always_comb begin
    if (&port_req) begin
      win_port = ~last_grant_reg;
    end else begin
      win_port = ~port_req[0];
    end
  end
`else
  // Fixed priority: port 0 whenever it asks, otherwise port 1
  assign win_port = ~port_req[0];
`endif

  // ---------------------------------------------------------------------
  // Transaction sequencing: next-state and datapath updates
  // ---------------------------------------------------------------------
  // Walk IDLE -> ISSUE -> WAIT -> DONE, latching the winner and its result
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    wdata_next   = wdata_reg;
    wd_next      = wd_reg;
    timeout_next = timeout_reg;
    rd_load      = '0;
    rd_value     = mem_rdata;

    case (state_reg)
      IDLE: begin
        // Arbitration happens only here; mid-transaction requests wait
        if (can_grant) begin
          grant_next = win_port;
          addr_next  = port_addr[win_port];
          we_next    = port_we[win_port];
          wdata_next = port_wdata[win_port];
          wd_next    = '0;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_busy) begin
          state_next = WAIT;
        end else begin
          wd_next = wd_inc;
          // Encoder never started: give up, report it, return zero data
          if (&wd_inc) begin
            timeout_next      = 1'b1;
            rd_load[grant_reg] = 1'b1;
            rd_value          = '0;
            state_next        = DONE;
          end
        end
      end

      WAIT: begin
        // Falling busy means the encoder finished; its data is valid now.
        // Writes capture too, so rdata always reflects the last completion.
        if (!mem_busy) begin
          rd_load[grant_reg] = 1'b1;
          rd_value           = mem_rdata;
          state_next         = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Register the sequencer state, latched request and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      wdata_reg   <= wdata_next;
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end

  // ---------------------------------------------------------------------
  // Per-port read data registers and acknowledge decode
  // ---------------------------------------------------------------------
  logic [NUM_PORTS-1:0] ack_vec;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      // Only the granted port's register is ever loaded; the other holds
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg[gi] <= '0;
        end else if (rd_load[gi]) begin
          rdata_reg[gi] <= rd_value;
        end
      end

      assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign p0_ack   = ack_vec[0];
  assign p1_ack   = ack_vec[1];
  assign p0_rdata = rdata_reg[0];
  assign p1_rdata = rdata_reg[1];

  // Request is held through ISSUE and WAIT, dropped as the result is taken
  assign mem_request      = (state_reg == ISSUE) || (state_reg == WAIT);
  assign mem_address      = addr_reg;
  assign mem_write_enable = we_reg;
  assign mem_wdata        = wdata_reg;

  assign grant       = grant_reg;
  assign active      = (state_reg != IDLE);
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter. A small behavioural encoder with a
// sparse memory answers the request/busy handshake. A transaction-level model
// predicts every output every cycle; directed checks pin key literal values.
// Build with or without SRAM_ARB_ROUND_ROBIN_EN; the expectations follow it.
module tb_sram_port_arbiter;

  localparam int WW = 16;
  localparam int AW = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic [WW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack, p1_ack;
  logic [WW-1:0] p0_rdata, p1_rdata;
  logic          mem_request;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic          mem_busy = 1'b0;
  logic          mem_initialized = 1'b0;
  logic          grant, active, timeout_err;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_request(mem_request), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_initialized(mem_initialized),
    .grant(grant), .active(active), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_print = 0;
  int p0_ack_cnt = 0;
  int p1_ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_print < 40)
        $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      n_print++;
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural encoder: accepts a request once it has seen request low,
  // stays busy for enc_len cycles, then returns memory contents at the
  // address (after applying a write). enc_dead keeps it from ever starting.
  // ---------------------------------------------------------------------
  logic          enc_dead = 1'b0;
  int            enc_len = 2;
  logic [WW-1:0] sram [logic [AW-1:0]];

  initial begin : encoder_model
    logic          armed;
    logic          e_busy;
    int            e_cnt;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [WW-1:0] e_wdata;
    armed = 1'b1; e_busy = 1'b0; e_cnt = 0;
    e_addr = '0; e_we = 1'b0; e_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        e_busy = 1'b0; mem_busy = 1'b0; armed = 1'b1;
      end else begin
        if (!mem_request) armed = 1'b1;
        if (e_busy) begin
          if (e_cnt > 1) begin
            e_cnt--;
          end else begin
            if (e_we) sram[e_addr] = e_wdata;
            mem_rdata = sram.exists(e_addr) ? sram[e_addr] : '0;
            e_busy = 1'b0; mem_busy = 1'b0; armed = 1'b0;
          end
        end else if (mem_request && armed && !enc_dead) begin
          e_busy = 1'b1; mem_busy = 1'b1;
          e_addr = mem_address; e_we = mem_write_enable; e_wdata = mem_wdata;
          e_cnt = enc_len;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transaction-level reference and per-cycle compare. Just after each
  // rising edge the inputs on the wires are the ones the DUT sampled on
  // that edge, so the model is advanced with them and then compared.
  // ---------------------------------------------------------------------
  initial begin : compare_model
    logic          m_open, m_busy_seen, m_ack, m_grant, m_last, m_to, m_we, w;
    int            m_wd;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_wdata, m_rd0, m_rd1;
    m_open = 0; m_busy_seen = 0; m_ack = 0; m_grant = 0; m_last = 1; m_to = 0;
    m_we = 0; m_wd = 0; m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0; w = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_open = 0; m_busy_seen = 0; m_ack = 0; m_grant = 0; m_last = 1; m_to = 0;
        m_we = 0; m_wd = 0; m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
      end else if (m_ack) begin
        m_ack = 0;
      end else if (!m_open) begin
        if (mem_initialized && !mem_busy && (p0_req || p1_req)) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          w = (p0_req && p1_req) ? !m_last : !p0_req;
`else
          w = !p0_req;
`endif
          m_last  = w;
          m_grant = w;
          m_addr  = w ? p1_addr  : p0_addr;
          m_we    = w ? p1_we    : p0_we;
          m_wdata = w ? p1_wdata : p0_wdata;
          m_open = 1; m_busy_seen = 0; m_wd = 0;
        end
      end else if (!m_busy_seen) begin
        if (mem_busy) begin
          m_busy_seen = 1;
        end else begin
          m_wd++;
          if (m_wd == (1 << TW) - 1) begin
            m_to = 1;
            if (m_grant) m_rd1 = '0; else m_rd0 = '0;
            m_open = 0; m_ack = 1;
          end
        end
      end else if (!mem_busy) begin
        if (m_grant) m_rd1 = mem_rdata; else m_rd0 = mem_rdata;
        m_open = 0; m_ack = 1;
      end

      chk("mem_request", 32'(mem_request), 32'(m_open));
      chk("active", 32'(active), 32'(m_open || m_ack));
      chk("p0_ack", 32'(p0_ack), 32'(m_ack && !m_grant));
      chk("p1_ack", 32'(p1_ack), 32'(m_ack && m_grant));
      chk("grant", 32'(grant), 32'(m_grant));
      chk("mem_address", 32'(mem_address), 32'(m_addr));
      chk("mem_write_enable", 32'(mem_write_enable), 32'(m_we));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("p0_rdata", 32'(p0_rdata), 32'(m_rd0));
      chk("p1_rdata", 32'(p1_rdata), 32'(m_rd1));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
      if (p0_ack) p0_ack_cnt++;
      if (p1_ack) p1_ack_cnt++;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------
  task automatic wait_ack(input int port, output logic [WW-1:0] rd, output int req_cycles);
    logic found;
    found = 1'b0; rd = '0; req_cycles = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_request) req_cycles++;
      if ((port == 0) ? p0_ack : p1_ack) begin
        rd = (port == 0) ? p0_rdata : p1_rdata;
        found = 1'b1;
      end
    end
    chk("ack_arrived", 32'(found), 32'd1);
  endtask

  task automatic start_req(input int port, input logic we, input logic [AW-1:0] addr,
                           input logic [WW-1:0] wdata);
    @(negedge clk);
    if (port == 0) begin
      p0_addr = addr; p0_we = we; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_addr = addr; p1_we = we; p1_wdata = wdata; p1_req = 1'b1;
    end
  endtask

  task automatic txn(input int port, input logic we, input logic [AW-1:0] addr,
                     input logic [WW-1:0] wdata, output logic [WW-1:0] rd);
    int cyc;
    start_req(port, we, addr, wdata);
    wait_ack(port, rd, cyc);
    @(negedge clk);
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  task automatic wait_busy();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = mem_busy;
    end
    chk("busy_seen", 32'(seen), 32'd1);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin : stimulus
    logic [WW-1:0] rd;
    int            cyc, p0c, p1c;
    logic          g [4];
    logic          exp_g [4];
    logic          got;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mem_request", 32'(mem_request), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Initialisation gating with a pending p1 read
    start_req(1, 1'b0, 16'h0040, 16'h0000);
    repeat (4) @(negedge clk);
    chk("gate_no_request", 32'(mem_request), 32'd0);
    mem_initialized = 1'b1;
    @(posedge clk);
    #1;
    chk("gate_request_next_cycle", 32'(mem_request), 32'd1);
    wait_ack(1, rd, cyc);
    chk("gate_rdata", 32'(rd), 32'h0000);
    @(negedge clk);
    p1_req = 1'b0;

    // Both ports requesting, both held across four completions
    @(negedge clk);
    p0_addr = 16'h0010; p0_we = 1'b0; p0_req = 1'b1;
    p1_addr = 16'h0020; p1_we = 1'b0; p1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      g[k] = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk);
        #1;
        if (p0_ack || p1_ack) begin
          g[k] = p1_ack;
          got = 1'b1;
        end
      end
      chk("tie_ack_arrived", 32'(got), 32'd1);
    end
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`else
    exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`endif
    for (int k = 0; k < 4; k++) chk($sformatf("tie_grant_%0d", k), 32'(g[k]), 32'(exp_g[k]));

    // p0 write then read back
    p0c = p0_ack_cnt; p1c = p1_ack_cnt;
    txn(0, 1'b1, 16'h1536, 16'h650F, rd);
    txn(0, 1'b0, 16'h1536, 16'h0000, rd);
    chk("wr_rd_data", 32'(rd), 32'h650F);
    chk("wr_rd_p0_acks", 32'(p0_ack_cnt - p0c), 32'd2);
    chk("wr_rd_p1_quiet", 32'(p1_ack_cnt - p1c), 32'd0);

    // Address changes while the encoder is busy must not reach the bus
    enc_len = 4;
    start_req(0, 1'b0, 16'h1536, 16'h0000);
    wait_busy();
    @(negedge clk);
    p0_addr = 16'h0040;
    @(posedge clk);
    #1;
    chk("stable_address", 32'(mem_address), 32'h1536);
    wait_ack(0, rd, cyc);
    chk("stable_rdata", 32'(rd), 32'h650F);
    @(negedge clk);
    p0_req = 1'b0;
    enc_len = 2;

    // Encoder never starts: watchdog completes the read with zero data
    enc_dead = 1'b1;
    start_req(0, 1'b0, 16'h0001, 16'h0000);
    wait_ack(0, rd, cyc);
    chk("wd_issue_cycles", 32'(cyc), 32'd15);
    chk("wd_rdata", 32'(rd), 32'h0000);
    chk("wd_flag", 32'(timeout_err), 32'd1);
    @(negedge clk);
    p0_req = 1'b0;
    enc_dead = 1'b0;
    txn(1, 1'b0, 16'h1536, 16'h0000, rd);
    chk("wd_recover_rdata", 32'(rd), 32'h650F);
    chk("wd_flag_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a transaction aborts it without an ack
    enc_len = 6;
    p0c = p0_ack_cnt;
    start_req(0, 1'b0, 16'h1536, 16'h0000);
    wait_busy();
    @(negedge clk);
    reset = 1'b1;
    p0_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_request", 32'(mem_request), 32'd0);
    chk("rst_mid_active", 32'(active), 32'd0);
    chk("rst_mid_timeout", 32'(timeout_err), 32'd0);
    chk("rst_mid_p0_rdata", 32'(p0_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    enc_len = 2;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_ack", 32'(p0_ack_cnt - p0c), 32'd0);
    txn(1, 1'b0, 16'h1536, 16'h0000, rd);
    chk("rst_mid_p1_read", 32'(rd), 32'h650F);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t, required finish earlier", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
